spi_tx_seq: RTL and testbench
=============================

SPI_TX_SEQ -- requirements
Module: spi_tx_seq

Interface — parameters
REQ-001 SHALL have parameter DEPTH, default 8: command FIFO depth, power of two, 2..64.
REQ-002 SHALL have parameter CS_GAP, default 4: cycles spi_cs held high between bytes, 1..255.
REQ-003 SHALL have parameter TIMEOUT, default 4095: max cycles in SEND without spi_valid, 1..65535.

Interface — ports
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port wr_en  input  1  push request, one byte per cycle.
REQ-007 SHALL have port wr_data  input  8  byte to transmit.
REQ-008 SHALL have port wr_dc  input  1  LCD data/command flag for wr_data (1=data, 0=command).
REQ-009 SHALL have port fifo_full  output  1  FIFO holds DEPTH entries.
REQ-010 SHALL have port fifo_empty  output  1  FIFO holds 0 entries.
REQ-011 SHALL have port spi_data  output  8  byte presented to the SPI byte transmitter.
REQ-012 SHALL have port spi_cs  output  1  active-low enable to the SPI byte transmitter and LCD chip select.
REQ-013 SHALL have port spi_valid  input  1  one-cycle end-of-byte pulse from the SPI byte transmitter.
REQ-014 SHALL have port lcd_dc  output  1  LCD D/C pin, stable for the whole byte.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when the FIFO drains and the last byte's gap ends.
REQ-017 SHALL have port timeout_err  output  1  one-cycle pulse on SEND watchdog expiry.
REQ-018 SHALL have port overflow  output  1  one-cycle pulse when a push is dropped.

Function
REQ-019 FIFO SHALL store {wr_dc, wr_data} (9 bits); push accepted when wr_en=1 and fifo_full=0.
REQ-020 Push with fifo_full=1 SHALL be dropped and overflow SHALL pulse the next cycle, even if a pop occurs in the same cycle.
REQ-021 Pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits; simultaneous push and pop with 0 < occupancy < DEPTH SHALL leave occupancy unchanged.
REQ-022 FSM states SHALL be IDLE, LOAD, SEND, GAP.
REQ-023 IDLE: spi_cs=1; when fifo_empty=0, SHALL go to LOAD next cycle.
REQ-024 LOAD (1 cycle): SHALL pop the FIFO head, register it onto spi_data/lcd_dc, keep spi_cs=1, go to SEND.
REQ-025 SEND: spi_cs=0, spi_data/lcd_dc held; watchdog counts from 0 each cycle; spi_valid=1 SHALL go to GAP.
REQ-026 SEND: watchdog reaching TIMEOUT without spi_valid SHALL pulse timeout_err and go to GAP; the byte is discarded, not retried.
REQ-027 spi_valid outside SEND SHALL be ignored.
REQ-028 GAP: spi_cs=1 for exactly CS_GAP cycles, then go to LOAD if FIFO is non-empty, else to IDLE with done pulsed in the same transition cycle.
REQ-029 spi_data and lcd_dc SHALL hold their last value outside LOAD updates.
REQ-030 Pushes during any state SHALL be accepted per REQ-019; the FSM only pops in LOAD.
REQ-031 Latency from the first push into an empty idle block to spi_cs falling SHALL be 3 cycles: push edge, IDLE→LOAD, LOAD→SEND.

Reset
REQ-032 Asserting reset at any time, including mid-SEND, SHALL immediately force: state IDLE, FIFO empty (fifo_empty=1, fifo_full=0), spi_cs=1, spi_data=8'h00, lcd_dc=0, busy=0, done=0, timeout_err=0, overflow=0, watchdog and gap counters 0.
REQ-033 Bytes in flight or queued at reset SHALL be lost; no done pulse SHALL follow reset.

Verification
REQ-034 Push {dc=0,8'h2A}, then model spi_valid 20 cycles after spi_cs falls → spi_cs low exactly 3 cycles after the push, spi_data=8'h2A, lcd_dc=0, spi_cs high 4 cycles, done pulses once, busy returns 0.
REQ-035 Push 3 bytes back-to-back (8'h11 dc=0, 8'h22 dc=1, 8'h33 dc=1) → three SEND windows in order with matching lcd_dc, each separated by exactly CS_GAP=4 high cycles, single done after the third.
REQ-036 Push 9 bytes in consecutive cycles with DEPTH=8 while the FSM is stalled in SEND → 9th push dropped with one overflow pulse, fifo_full=1; all 8 stored bytes later sent in order.
REQ-037 Never assert spi_valid, TIMEOUT=100 → timeout_err pulses after 100 SEND cycles, GAP follows, next queued byte then loaded.
REQ-038 Assert reset mid-SEND with 5 bytes queued → spi_cs=1 and fifo_empty=1 immediately, no done, no further SEND windows after release.
REQ-039 Push and pop in the same cycle with occupancy 1 → occupancy stays 1, no overflow, byte order preserved.

Source files
------------

// File: rtl/spi_tx_seq.sv
// Command FIFO feeding an SPI byte transmitter with LCD D/C steering.
// Four-state sequencer: IDLE -> LOAD -> SEND -> GAP, plus send watchdog and done/overflow pulses.
module spi_tx_seq #(
   parameter int DEPTH   = 8,
   parameter int CS_GAP  = 4,
   parameter int TIMEOUT = 4095
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       wr_dc,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic [7:0] spi_data,
   output logic       spi_cs,
   input  logic       spi_valid,
   output logic       lcd_dc,
   output logic       busy,
   output logic       done,
   output logic       timeout_err,
   output logic       overflow
);

   localparam int              AW        = $clog2(DEPTH);
   localparam int              CW        = AW + 1;
   localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
   localparam logic [15:0]     WD_LAST   = 16'(TIMEOUT - 1);
   localparam logic [7:0]      GAP_LAST  = 8'(CS_GAP - 1);
   localparam logic [7:0]      GAP_EARLY = 8'(CS_GAP - 2);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            w_done_set;
   logic            w_timeout_set;

   logic [8:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_push;
   logic            w_pop;

   logic [15:0]     r_wd;
   logic [7:0]      r_gap;
   logic [7:0]      r_spi_data;
   logic            r_lcd_dc;
   logic            r_spi_cs;
   logic            r_done;
   logic            r_timeout_err;
   logic            r_overflow;

   assign fifo_full  = (r_count == FULL_CNT);
   assign fifo_empty = (r_count == '0);
   assign w_push     = wr_en && !fifo_full;
   assign w_pop      = (r_state == LOAD);

   // Storage has no reset: occupancy and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {wr_dc, wr_data};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // The LOAD cycle also holds chip select high, so a back-to-back byte leaves
   // GAP one cycle early to keep the high time between bytes at exactly CS_GAP.
   always_comb begin
      w_state_next  = r_state;
      w_done_set    = 1'b0;
      w_timeout_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (!fifo_empty) begin
               w_state_next = LOAD;
            end
         end
         LOAD: begin
            w_state_next = SEND;
         end
         SEND: begin
            if (spi_valid || (r_wd == WD_LAST)) begin
               w_timeout_set = !spi_valid;
               w_state_next  = ((CS_GAP == 1) && !fifo_empty) ? LOAD : GAP;
            end
         end
         GAP: begin
            if (r_gap == GAP_LAST) begin
               if (!fifo_empty) begin
                  w_state_next = LOAD;
               end else begin
                  w_state_next = IDLE;
                  w_done_set   = 1'b1;
               end
            end else if ((CS_GAP > 1) && (r_gap == GAP_EARLY) && !fifo_empty) begin
               w_state_next = LOAD;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wd          <= '0;
         r_gap         <= '0;
         r_spi_data    <= 8'h00;
         r_lcd_dc      <= 1'b0;
         r_spi_cs      <= 1'b1;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_wd          <= ((r_state == SEND) && (w_state_next == SEND)) ? r_wd + 16'd1 : 16'd0;
         r_gap         <= ((r_state == GAP) && (w_state_next == GAP)) ? r_gap + 8'd1 : 8'd0;
         r_spi_cs      <= (w_state_next != SEND);
         r_done        <= w_done_set;
         r_timeout_err <= w_timeout_set;
         r_overflow    <= wr_en && fifo_full;
         if (r_state == LOAD) begin
            {r_lcd_dc, r_spi_data} <= r_mem[r_rd_ptr];
         end
      end
   end

   assign spi_data    = r_spi_data;
   assign lcd_dc      = r_lcd_dc;
   assign spi_cs      = r_spi_cs;
   assign busy        = (r_state != IDLE);
   assign done        = r_done;
   assign timeout_err = r_timeout_err;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_spi_tx_seq.sv
// Directed and randomized bench for spi_tx_seq: a responder models the SPI byte
// transmitter, a monitor records SEND windows, and a queue model predicts the byte stream.
module tb_spi_tx_seq;

   localparam int DEPTH   = 8;
   localparam int CS_GAP  = 4;
   localparam int TIMEOUT = 100;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       wr_dc;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] spi_data;
   logic       spi_cs;
   logic       spi_valid;
   logic       lcd_dc;
   logic       busy;
   logic       done;
   logic       timeout_err;
   logic       overflow;

   spi_tx_seq #(.DEPTH(DEPTH), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .wr_dc       (wr_dc),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .spi_data    (spi_data),
      .spi_cs      (spi_cs),
      .spi_valid   (spi_valid),
      .lcd_dc      (lcd_dc),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // responder controls
   bit resp_en    = 1'b0;
   bit noise_en   = 1'b0;
   int resp_delay = 20;

   // monitor records
   bit         mon_clr = 1'b0;
   logic [8:0] obs_q[$];
   int         gap_q[$];
   int         low_q[$];
   int         done_cnt;
   int         to_cnt;
   int         ovf_cnt;

   // reference model
   logic [8:0] exp_q[$];
   int         n_acc;
   int         n_drop;

   int n_assert = 0;
   int n_fail   = 0;

   // SPI byte transmitter model: pulses spi_valid resp_delay cycles into each low window.
   initial begin
      int low_cnt;
      low_cnt   = 0;
      spi_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (spi_cs === 1'b0) begin
            low_cnt++;
            spi_valid = resp_en && (low_cnt == resp_delay);
         end else begin
            low_cnt   = 0;
            spi_valid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   // Window monitor sampled on the falling edge.
   initial begin
      logic prev_cs;
      bit   have_win;
      int   high_run;
      int   low_run;
      prev_cs  = 1'b1;
      have_win = 1'b0;
      high_run = 0;
      low_run  = 0;
      done_cnt = 0;
      to_cnt   = 0;
      ovf_cnt  = 0;
      forever begin
         @(negedge clk);
         if (mon_clr) begin
            obs_q.delete();
            gap_q.delete();
            low_q.delete();
            done_cnt = 0;
            to_cnt   = 0;
            ovf_cnt  = 0;
            prev_cs  = 1'b1;
            have_win = 1'b0;
            high_run = 0;
            low_run  = 0;
         end else begin
            if (done === 1'b1)        done_cnt++;
            if (timeout_err === 1'b1) to_cnt++;
            if (overflow === 1'b1)    ovf_cnt++;
            if (spi_cs === 1'b0) begin
               if (prev_cs === 1'b1) begin
                  obs_q.push_back({lcd_dc, spi_data});
                  if (have_win) gap_q.push_back(high_run);
                  have_win = 1'b1;
                  low_run  = 0;
               end
               low_run++;
            end else begin
               if (prev_cs === 1'b0) begin
                  low_q.push_back(low_run);
                  high_run = 0;
               end
               high_run++;
            end
            prev_cs = spi_cs;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic new_scenario();
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
      exp_q.delete();
      n_acc  = 0;
      n_drop = 0;
   endtask

   // Model: a push is kept if fewer than DEPTH accepted bytes are still waiting to start.
   task automatic push(input logic dc, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_dc   = dc;
      wr_data = d;
      if ((n_acc - obs_q.size()) < DEPTH) begin
         exp_q.push_back({dc, d});
         n_acc++;
      end else begin
         n_drop++;
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int n;
      n = 0;
      while (!((busy === 1'b0) && (fifo_empty === 1'b1)) && (n < max_cyc)) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_drain_in_time"}, 64'(n < max_cyc), 64'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_cs_low(input string tag, input int max_cyc);
      int n;
      n = 0;
      while ((spi_cs !== 1'b0) && (n < max_cyc)) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_cs_low_in_time"}, 64'(n < max_cyc), 64'd1);
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_windows"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; (i < exp_q.size()) && (i < obs_q.size()); i++) begin
         $display("%s txn %0d: dc=%0d data=%02h", tag, i, obs_q[i][8], obs_q[i][7:0]);
         check($sformatf("%s_byte%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
      end
      if (obs_q.size() > 0) begin
         check({tag, "_gap_count"}, 64'(gap_q.size()), 64'(obs_q.size() - 1));
      end
      for (int i = 0; i < gap_q.size(); i++) begin
         check($sformatf("%s_gap%0d", tag, i), 64'(gap_q[i]), 64'(CS_GAP));
      end
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_dc   = 1'b0;
      wr_data = 8'h00;
      n_acc   = 0;
      n_drop  = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", 64'(spi_cs), 64'd1);
      check("rst_empty", 64'(fifo_empty), 64'd1);
      check("rst_full", 64'(fifo_full), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_data", 64'(spi_data), 64'h00);
      check("rst_flags", 64'({lcd_dc, done, timeout_err, overflow}), 64'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // single byte, three-edge latency, 20-cycle transmitter
      new_scenario();
      resp_en    = 1'b1;
      resp_delay = 20;
      push(1'b0, 8'h2A);
      check("lat_after_push_edge", 64'(spi_cs), 64'd1);
      @(posedge clk);
      #1;
      check("lat_after_load_edge", 64'(spi_cs), 64'd1);
      @(posedge clk);
      #1;
      check("lat_cs_low_3_edges", 64'(spi_cs), 64'd0);
      check("single_data", 64'(spi_data), 64'h2A);
      check("single_dc", 64'(lcd_dc), 64'd0);
      drain("single", 500);
      check_stream("single");
      check("single_low_len", 64'(low_q.size() > 0 ? low_q[0] : -1), 64'(resp_delay));
      check("single_done", 64'(done_cnt), 64'd1);
      check("single_busy", 64'(busy), 64'd0);

      // three back-to-back bytes
      new_scenario();
      resp_delay = 7;
      push(1'b0, 8'h11);
      push(1'b1, 8'h22);
      push(1'b1, 8'h33);
      drain("burst3", 500);
      check_stream("burst3");
      check("burst3_done", 64'(done_cnt), 64'd1);

      // overflow while stalled in SEND; stalled byte times out
      new_scenario();
      resp_en  = 1'b0;
      noise_en = 1'b0;
      push(1'b0, 8'hA5);
      wait_cs_low("ovf", 20);
      for (int i = 0; i < 9; i++) begin
         push(1'(i), 8'(8'h30 + i));
      end
      check("ovf_full_flag", 64'(fifo_full), 64'd1);
      resp_delay = 3;
      resp_en    = 1'b1;
      drain("ovf", 3000);
      check_stream("ovf");
      check("ovf_pulses", 64'(ovf_cnt), 64'(n_drop));
      check("ovf_model_drops", 64'(n_drop), 64'd1);
      check("ovf_timeouts", 64'(to_cnt), 64'd1);
      check("ovf_done", 64'(done_cnt), 64'd1);

      // watchdog: transmitter never answers
      new_scenario();
      resp_en = 1'b0;
      push(1'b0, 8'h5C);
      push(1'b1, 8'hC5);
      drain("wdog", 1000);
      check_stream("wdog");
      check("wdog_low_windows", 64'(low_q.size()), 64'd2);
      for (int i = 0; i < low_q.size(); i++) begin
         check($sformatf("wdog_low_len%0d", i), 64'(low_q[i]), 64'(TIMEOUT));
      end
      check("wdog_pulses", 64'(to_cnt), 64'd2);
      check("wdog_done", 64'(done_cnt), 64'd1);

      // push coinciding with the LOAD pop at occupancy 1
      new_scenario();
      resp_en    = 1'b1;
      resp_delay = 5;
      push(1'b1, 8'h9E);
      @(posedge clk);
      #1;
      push(1'b0, 8'h4D);
      check("pp_not_empty", 64'(fifo_empty), 64'd0);
      check("pp_not_full", 64'(fifo_full), 64'd0);
      drain("pp", 500);
      check_stream("pp");
      check("pp_overflow", 64'(ovf_cnt), 64'd0);
      check("pp_done", 64'(done_cnt), 64'd1);

      // randomized bursts with spurious spi_valid outside SEND
      for (int b = 0; b < 3; b++) begin
         int k;
         new_scenario();
         noise_en   = 1'b1;
         resp_delay = $urandom_range(1, 30);
         k          = $urandom_range(1, DEPTH);
         for (int i = 0; i < k; i++) begin
            push(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         end
         drain($sformatf("rnd%0d", b), 3000);
         check_stream($sformatf("rnd%0d", b));
         for (int i = 0; i < low_q.size(); i++) begin
            check($sformatf("rnd%0d_low%0d", b, i), 64'(low_q[i]), 64'(resp_delay));
         end
         check($sformatf("rnd%0d_done", b), 64'(done_cnt), 64'd1);
         check($sformatf("rnd%0d_timeouts", b), 64'(to_cnt), 64'd0);
         check($sformatf("rnd%0d_overflow", b), 64'(ovf_cnt), 64'd0);
      end
      noise_en = 1'b0;

      // asynchronous reset in the middle of SEND with five bytes queued
      new_scenario();
      resp_delay = 20;
      for (int i = 0; i < 6; i++) begin
         push(1'b1, 8'(8'hE0 + i));
      end
      wait_cs_low("midrst", 20);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      check("midrst_cs", 64'(spi_cs), 64'd1);
      check("midrst_empty", 64'(fifo_empty), 64'd1);
      check("midrst_full", 64'(fifo_full), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_data", 64'({lcd_dc, spi_data}), 64'd0);
      new_scenario();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (60) begin
         @(posedge clk);
         #1;
      end
      check("midrst_no_windows", 64'(obs_q.size()), 64'd0);
      check("midrst_no_done", 64'(done_cnt), 64'd0);
      check("midrst_idle", 64'({busy, spi_cs, fifo_empty}), 64'b011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
